rst_seq: RTL and testbench

Parametrised reset sequencer for the SoC top level. It takes the board-level asynchronous active-low reset and a software reset request, and produces CHANNELS per-domain active-high resets for the CPU, bus and peripherals. Each reset asserts asynchronously, is released synchronously after a stretch interval, and the channels are released in a fixed, staggered order. It replaces the single bare reset line currently fanned out across the SoC.

---
 rtl/rst_seq.sv | 98 +++++++++
 tb/tb_rst_seq.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/rst_seq.sv
// rst_seq: staggered per-domain reset sequencer with sync release, stretch and software restart
module rst_seq #(
   parameter int CHANNELS    = 4,
   parameter int SYNC_STAGES = 2,
   parameter int STRETCH     = 16,
   parameter int STAGGER     = 4
) (
   input  logic                rst_seq_clk_i,
   input  logic                rst_seq_rst_i,
   input  logic                rst_seq_sw_req_i,
   input  logic [CHANNELS-1:0] rst_seq_hold_i,
   output logic [CHANNELS-1:0] rst_seq_rst_o,
   output logic                rst_seq_done_o,
   output logic                rst_seq_cause_o
);
   localparam int CW = $clog2(STRETCH + 1);
   localparam int SW = $clog2(STAGGER + 1);
   localparam int KW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
      $error("rst_seq: CHANNELS must be 1..16");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("rst_seq: SYNC_STAGES must be >= 2");
   end
   if (STRETCH < 1) begin : g_bad_stretch
      $error("rst_seq: STRETCH must be >= 1");
   end
   if (STAGGER < 1) begin : g_bad_stagger
      $error("rst_seq: STAGGER must be >= 1");
   end

   typedef enum logic [1:0] {ST_SYNC, ST_STRETCH, ST_RELEASE, ST_RUN} state_t;

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic [CW-1:0]          cnt_q;
   logic [SW-1:0]          stg_q;
   logic [KW-1:0]          k_q;
   logic [CHANNELS-1:0]    rst_q;
   logic                   done_q;
   logic                   cause_q;
   logic                   rel_ok;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
   assign rel_ok = ((state_q == ST_STRETCH && cnt_q == '0) || (state_q == ST_RELEASE && stg_q == '0))
                   && !rst_seq_hold_i[k_q];

   // Sequencer: sync release, stretch, staggered per-channel release, software restart
   always_ff @(posedge rst_seq_clk_i or negedge rst_seq_rst_i) begin
      if (!rst_seq_rst_i) begin
         state_q <= ST_SYNC;
         sync_q  <= '0;
         cnt_q   <= '0;
         stg_q   <= '0;
         k_q     <= '0;
         rst_q   <= '1;
         done_q  <= 1'b0;
         cause_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         if (state_q != ST_SYNC && rst_seq_sw_req_i) begin
            state_q <= ST_STRETCH;
            cnt_q   <= CW'(STRETCH - 1);
            k_q     <= '0;
            rst_q   <= '1;
            done_q  <= 1'b0;
            cause_q <= 1'b1;
         end else begin
            case (state_q)
               ST_SYNC: if (sync_d[SYNC_STAGES-1] && !sync_q[SYNC_STAGES-1]) begin
                  state_q <= ST_STRETCH;
                  cnt_q   <= CW'(STRETCH - 1);
                  k_q     <= '0;
               end
               ST_STRETCH: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
               else begin
                  state_q <= ST_RELEASE;
                  stg_q   <= '0;
               end
               ST_RELEASE: if (stg_q != '0) stg_q <= stg_q - 1'b1;
               default: done_q <= 1'b1;
            endcase
            if (rel_ok) begin
               rst_q[k_q] <= 1'b0;
               stg_q      <= SW'(STAGGER - 1);
               if (k_q == KW'(CHANNELS - 1)) state_q <= ST_RUN;
               else k_q <= k_q + 1'b1;
            end
         end
      end
   end

   assign rst_seq_rst_o   = rst_q;
   assign rst_seq_done_o  = done_q;
   assign rst_seq_cause_o = cause_q;
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed timing checks plus randomized run against an event-time reference model
module tb_rst_seq;
   localparam int CH = 4, SS = 2, ST = 16, SG = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sw = 1'b0;
   logic [3:0] hold = 4'h0;
   logic [3:0] d_rst;
   logic       d_done, d_cause;
   logic [0:0] s_rst;
   logic       s_done, s_cause;

   int checks = 0, errors = 0;

   rst_seq #(.CHANNELS(CH), .SYNC_STAGES(SS), .STRETCH(ST), .STAGGER(SG)) dut (
      .rst_seq_clk_i(clk), .rst_seq_rst_i(rst_n), .rst_seq_sw_req_i(sw), .rst_seq_hold_i(hold),
      .rst_seq_rst_o(d_rst), .rst_seq_done_o(d_done), .rst_seq_cause_o(d_cause));

   rst_seq #(.CHANNELS(1), .SYNC_STAGES(3), .STRETCH(1), .STAGGER(1)) dut_s (
      .rst_seq_clk_i(clk), .rst_seq_rst_i(rst_n), .rst_seq_sw_req_i(1'b0), .rst_seq_hold_i(1'b0),
      .rst_seq_rst_o(s_rst), .rst_seq_done_o(s_done), .rst_seq_cause_o(s_cause));

   always #5 clk = ~clk;

   // Reference model: each channel may fall at the first edge at or after its earliest time with hold low
   logic [3:0] m_rst;
   logic       m_done, m_cause;
   int         e, nxt, earliest;
   bit         armed;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rst = 4'hF; m_done = 0; m_cause = 0; e = 0; nxt = 0; armed = 0; earliest = 0;
      end else begin
         e++;
         if (e == SS) begin
            armed = 1; nxt = 0; earliest = e + ST;
         end else if (e > SS && sw) begin
            m_rst = 4'hF; m_done = 0; m_cause = 1; nxt = 0; earliest = e + ST;
         end else if (armed && nxt < CH && e >= earliest && !hold[nxt]) begin
            m_rst[nxt] = 1'b0; nxt++; earliest = e + SG;
         end else if (armed && nxt == CH) m_done = 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, e);
      end
   endtask

   task automatic step();
      @(negedge clk);
      chk("model_rst", 32'(d_rst), 32'(m_rst));
      chk("model_done", 32'(d_done), 32'(m_done));
      chk("model_cause", 32'(d_cause), 32'(m_cause));
   endtask

   task automatic wait_edge(input int n);
      int b = 0;
      while (e < n && b < 300) begin
         step();
         b++;
      end
      chk("edge_reached", 32'(e), 32'(n));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      // External reset, default timing, plus the small-parameter instance
      repeat (5) step();
      chk("rst_during_reset", 32'(d_rst), 32'hF);
      chk("done_during_reset", 32'(d_done), 32'h0);
      chk("cause_during_reset", 32'(d_cause), 32'h0);
      chk("small_rst_reset", 32'(s_rst), 32'h1);
      rst_n = 1'b1;
      wait_edge(3);  chk("small_rst_e3", 32'(s_rst), 32'h1);
      wait_edge(4);  chk("small_rst_e4", 32'(s_rst), 32'h0); chk("small_done_e4", 32'(s_done), 32'h0);
      wait_edge(5);  chk("small_done_e5", 32'(s_done), 32'h1); chk("small_cause", 32'(s_cause), 32'h0);
      wait_edge(17); chk("ext_e17", 32'(d_rst), 32'hF);
      wait_edge(18); chk("ext_ch0_e18", 32'(d_rst), 32'hE);
      wait_edge(22); chk("ext_ch1_e22", 32'(d_rst), 32'hC);
      wait_edge(26); chk("ext_ch2_e26", 32'(d_rst), 32'h8);
      wait_edge(30); chk("ext_ch3_e30", 32'(d_rst), 32'h0); chk("ext_done_e30", 32'(d_done), 32'h0);
      wait_edge(31); chk("ext_done_e31", 32'(d_done), 32'h1); chk("ext_cause", 32'(d_cause), 32'h0);
      // Hold stall on channel 1, then software request in RUN
      hold = 4'b0010;
      do_reset();
      wait_edge(18); chk("hold_ch0_e18", 32'(d_rst), 32'hE);
      wait_edge(39); chk("hold_stall_e39", 32'(d_rst), 32'hE);
      hold = 4'h0;
      wait_edge(40); chk("hold_ch1_e40", 32'(d_rst), 32'hC);
      wait_edge(44); chk("hold_ch2_e44", 32'(d_rst), 32'h8);
      wait_edge(48); chk("hold_ch3_e48", 32'(d_rst), 32'h0);
      wait_edge(49); chk("hold_done_e49", 32'(d_done), 32'h1);
      sw = 1'b1;
      wait_edge(50); sw = 1'b0;
      chk("sw_run_rst", 32'(d_rst), 32'hF); chk("sw_run_done", 32'(d_done), 32'h0);
      chk("sw_run_cause", 32'(d_cause), 32'h1);
      wait_edge(65); chk("sw_run_e65", 32'(d_rst), 32'hF);
      wait_edge(66); chk("sw_run_ch0_e66", 32'(d_rst), 32'hE);
      wait_edge(78); chk("sw_run_ch3_e78", 32'(d_rst), 32'h0);
      wait_edge(79); chk("sw_run_done_e79", 32'(d_done), 32'h1);
      // Software request mid-release: pulse, then held for 10 cycles
      do_reset();
      wait_edge(22); chk("mid_e22", 32'(d_rst), 32'hC);
      sw = 1'b1;
      wait_edge(23); sw = 1'b0;
      chk("mid_reassert", 32'(d_rst), 32'hF); chk("mid_cause", 32'(d_cause), 32'h1);
      wait_edge(38); chk("mid_e38", 32'(d_rst), 32'hF);
      wait_edge(39); chk("mid_ch0_e39", 32'(d_rst), 32'hE);
      do_reset();
      wait_edge(22); sw = 1'b1;
      wait_edge(32); sw = 1'b0;
      wait_edge(47); chk("held_e47", 32'(d_rst), 32'hF);
      wait_edge(48); chk("held_ch0_e48", 32'(d_rst), 32'hE);
      // Asynchronous reset between edges while mid-sequence
      wait_edge(53); chk("async_pre_rst", 32'(d_rst), 32'hC); chk("async_pre_cause", 32'(d_cause), 32'h1);
      #2 rst_n = 1'b0;
      #1 chk("async_rst_now", 32'(d_rst), 32'hF);
      chk("async_cause_now", 32'(d_cause), 32'h0);
      chk("async_done_now", 32'(d_done), 32'h0);
      step();
      step();
      rst_n = 1'b1;
      wait_edge(18); chk("async_ch0_e18", 32'(d_rst), 32'hE);
      wait_edge(30); chk("async_ch3_e30", 32'(d_rst), 32'h0);
      wait_edge(31); chk("async_done_e31", 32'(d_done), 32'h1);
      // Randomized holds, software requests and occasional external resets
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) hold[$urandom_range(0, 3)] ^= 1'b1;
         sw = ($urandom_range(0, 59) == 0);
         rst_n = ($urandom_range(0, 249) != 0);
         step();
      end
      sw = 1'b0;
      rst_n = 1'b1;
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
